uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
Round-robin arbiter that lets NUM_REQ requesters share one uart_tx_ctrl transmitter. It accepts one byte at a time from the winning requester and drives the transmitter's send/data inputs. It then tracks the transmitter's ready signal until the frame completes. It sits between the application FSMs (button handlers, string senders) and uart_tx_ctrl.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width per requester
RDY_TIMEOUT, 16, cycles to wait for uart_rdy to fall after a send pulse before aborting

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req  input  NUM_REQ  level request per requester; held until ack
req_data  input  NUM_REQ*DATA_W  flattened bytes; requester i uses bits [i*DATA_W +: DATA_W]
ack  output  NUM_REQ  one-cycle pulse: byte of requester i latched; requester may change data or drop req
done  output  NUM_REQ  one-cycle pulse: frame for requester i fully transmitted (uart_rdy high again)
uart_send  output  1  to uart_tx_ctrl send input
uart_data  output  DATA_W  to uart_tx_ctrl data input
uart_rdy  input  1  from uart_tx_ctrl ready output
busy  output  1  high in any state other than IDLE
grant_idx  output  3  index of the current or last granted requester
err_timeout  output  1  one-cycle pulse when the RDY_TIMEOUT abort occurs

Behaviour:
- All outputs are registered. Reset values: ack=0, done=0, uart_send=0, uart_data=0, busy=0, grant_idx=0, err_timeout=0, state=IDLE, rr_ptr=NUM_REQ-1, timeout counter=0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: if |req and uart_rdy==1:
  - winner = first set req bit, searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - Latch uart_data <= req_data[winner], grant_idx <= winner, rr_ptr <= winner.
  - Pulse ack[winner] for one cycle; go to ISSUE.
  - With no req, or with uart_rdy==0, stay in IDLE (no grant is made).
- ISSUE: uart_send=1 for exactly this one cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - uart_rdy==0 -> WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches RDY_TIMEOUT-1 with uart_rdy still 1, pulse err_timeout and go to IDLE; no done pulse is issued.
- WAIT_DONE: uart_rdy==1 -> pulse done[grant_idx] and go to IDLE.
- Latency:
  - req rising in IDLE with uart_rdy high -> ack on the next edge.
  - uart_send rises one cycle after ack.
  - Minimum re-grant is the cycle after done.
- Only one ack/done bit is ever set at a time; ack and done are never set in the same cycle.
- A req bit that drops before being granted is simply skipped. A req still high after its own ack is a new request, but round-robin forces the other pending requesters ahead of it.
- Simultaneous requests: all requesters are served in rotation order; no starvation while each holds req.
- Reset mid-operation:
  - Outputs clear immediately (asynchronous); uart_send drops.
  - uart_tx_ctrl may still be finishing a frame. The IDLE grant condition (uart_rdy==1) prevents corrupting that frame.
- NUM_REQ < 8: unused grant_idx MSBs read 0.

Optional Feature:
Macro UART_ARB_FIXED_PRIO_EN.
- Defined: winner is the lowest-index set req bit; rr_ptr is unused and held at reset value.
- Undefined: round-robin as described above.
- All other timing and handshakes are identical in both modes.

Test Plan:
- Single requester: req[0]=1, req_data byte0=8'h41, uart_rdy model drops 1 cycle after send and stays low 10 cycles -> ack[0] once, uart_send one cycle with uart_data=8'h41, done[0] 11 cycles after the send pulse, busy low afterwards.
- Contention: req=4'b0011 held, bytes 8'h41/8'h42 -> send order 0x41, 0x42, 0x41, 0x42; grant_idx alternates 0,1.
- Full rotation: req=4'b1111 held from reset -> grant order 0,1,2,3,0; then drop req[1] -> order continues 2,3,0,2,3.
- Timeout: uart_rdy stuck at 1 -> err_timeout pulses 16 cycles after uart_send, no done, state returns to IDLE and re-grants.
- Reset mid-frame: assert rst during WAIT_DONE while uart_rdy=0 -> outputs 0 immediately; after release with req[2]=1, no ack until uart_rdy returns 1.
- UART_ARB_FIXED_PRIO_EN defined, req=4'b0101 held -> requester 0 granted every time, requester 2 never; after req[0] drops, requester 2 is granted.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Requester/transmitter-side bundle for uart_tx_arb.
// master: the arbiter; slave: the requesters and the uart_tx_ctrl ready line.
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        done;
  logic                      uart_send;
  logic [DATA_W-1:0]         uart_data;
  logic                      uart_rdy;
  logic                      busy;
  logic [2:0]                grant_idx;
  logic                      err_timeout;

  modport master (
    input  req, req_data, uart_rdy,
    output ack, done, uart_send, uart_data, busy, grant_idx, err_timeout
  );

  modport slave (
    output req, req_data, uart_rdy,
    input  ack, done, uart_send, uart_data, busy, grant_idx, err_timeout
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx_ctrl between NUM_REQ requesters.
// Define UART_ARB_FIXED_PRIO_EN to select lowest-index-wins fixed priority instead.
module uart_tx_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int RDY_TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_arb_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam int CNT_W = $clog2(RDY_TIMEOUT + 1);

  state_t             state_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] done_q;
  logic               send_q;
  logic [DATA_W-1:0]  data_q;
  logic               busy_q;
  logic [2:0]         gidx_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;
`ifndef UART_ARB_FIXED_PRIO_EN
  logic [2:0]         rr_ptr_q;
`endif

  logic               win_vld_d;
  logic [2:0]         win_idx_d;
  logic [DATA_W-1:0]  win_data_d;

  // Rotating search done as two constant-index passes: above rr_ptr, then wrap to 0..rr_ptr.
  always_comb begin
    win_vld_d  = 1'b0;
    win_idx_d  = '0;
    win_data_d = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_vld_d && bus.req[i]) begin
        win_vld_d  = 1'b1;
        win_idx_d  = 3'(i);
        win_data_d = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
`else
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_vld_d && bus.req[i] && (3'(i) > rr_ptr_q)) begin
        win_vld_d  = 1'b1;
        win_idx_d  = 3'(i);
        win_data_d = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_vld_d && bus.req[i] && (3'(i) <= rr_ptr_q)) begin
        win_vld_d  = 1'b1;
        win_idx_d  = 3'(i);
        win_data_d = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ack_q    <= '0;
      done_q   <= '0;
      send_q   <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      gidx_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr_q <= 3'(NUM_REQ - 1);
`endif
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      send_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Granting only while uart_rdy is high protects a frame left running across a reset.
          if (win_vld_d && bus.uart_rdy) begin
            data_q   <= win_data_d;
            gidx_q   <= win_idx_d;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q <= win_idx_d;
`endif
            ack_q    <= NUM_REQ'(1) << win_idx_d;
            busy_q   <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          send_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.uart_rdy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == CNT_W'(RDY_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (bus.uart_rdy) begin
            done_q  <= NUM_REQ'(1) << gidx_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.done        = done_q;
  assign bus.uart_send   = send_q;
  assign bus.uart_data   = data_q;
  assign bus.busy        = busy_q;
  assign bus.grant_idx   = gidx_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb with a behavioural uart_tx_ctrl ready model.
// Expected grant order follows UART_ARB_FIXED_PRIO_EN when that macro is defined.
module tb_uart_tx_arb;
  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int RDY_TIMEOUT = 16;
  localparam int LOW_LEN     = 10;

  typedef struct packed {
    logic [2:0]        idx;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  uart_tx_arb_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arb #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .RDY_TIMEOUT(RDY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // Transmitter model: 0 normal frame of LOW_LEN cycles, 1 ready stuck high, 2 ready stuck low.
  int   rdy_mode = 0;
  int   low_cnt  = 0;
  logic rdy_m    = 1'b1;
  assign bus.uart_rdy = rdy_m;

  always @(negedge clk) begin
    case (rdy_mode)
      1: begin rdy_m <= 1'b1; low_cnt <= 0; end
      2: begin rdy_m <= 1'b0; low_cnt <= 0; end
      default: begin
        if (low_cnt != 0) begin
          low_cnt <= low_cnt - 1;
          if (low_cnt == 1) rdy_m <= 1'b1;
        end else if (bus.uart_send) begin
          rdy_m   <= 1'b0;
          low_cnt <= LOW_LEN;
        end else begin
          rdy_m <= 1'b1;
        end
      end
    endcase
  end

  function automatic exp_t exp_of(input int idx);
    exp_t e;
    e.idx  = 3'(idx);
    e.data = 8'h41 + 8'(idx);
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rdy_mode = 0;
    bus.req  = '0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_send(output logic [2:0] g, output logic [DATA_W-1:0] d,
                           output logic [NUM_REQ-1:0] a, output int lat, output bit ok);
    ok = 1'b0; g = '0; d = '0; a = '0; lat = 0;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin a = bus.ack; lat = 0; end
      else lat++;
      if (bus.uart_send) begin ok = 1'b1; g = bus.grant_idx; d = bus.uart_data; end
    end
  endtask

  task automatic wait_done(output logic [NUM_REQ-1:0] dn, output bit err, output int cyc,
                           output int extra, output bit ok);
    dn = '0; err = 1'b0; cyc = 0; extra = 0; ok = 1'b0;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk);
      cyc++;
      if (bus.uart_send || bus.ack != '0) extra++;
      if (bus.done != '0 || bus.err_timeout) begin
        ok = 1'b1; dn = bus.done; err = bus.err_timeout;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (bus.ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
    n_checks++; if (bus.done !== '0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.uart_send !== 1'b0) begin n_fail++; $display("FAIL reset_send: got %b want 0", bus.uart_send); end
    n_checks++; if (bus.uart_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.uart_data); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.grant_idx !== 3'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", bus.grant_idx); end
    n_checks++; if (bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_timeout); end
  endtask

  task automatic test_single();
    logic [2:0] g; logic [DATA_W-1:0] d; logic [NUM_REQ-1:0] a, dn;
    int lat, cyc, extra, stray; bit ok, err; exp_t e;
    do_reset();
    bus.req = 4'b0001;
    sb.push_back(exp_of(0));
    wait_send(g, d, a, lat, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || g !== e.idx || d !== e.data || a !== 4'b0001 || lat != 1) begin
      n_fail++;
      $display("FAIL single_send: ok=%0d grant=%0d data=%h ack=%b lat=%0d, want grant=%0d data=%h ack=0001 lat=1",
               ok, g, d, a, lat, e.idx, e.data);
    end
    bus.req = '0;
    wait_done(dn, err, cyc, extra, ok);
    n_checks++;
    if (!ok || dn !== 4'b0001 || err || cyc != LOW_LEN + 1 || extra != 0) begin
      n_fail++;
      $display("FAIL single_done: ok=%0d done=%b err=%0d cycles=%0d extra=%0d, want done=0001 err=0 cycles=%0d extra=0",
               ok, dn, err, cyc, extra, LOW_LEN + 1);
    end
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.busy || bus.ack != '0) stray++;
    end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL single_idle: busy/ack seen %0d cycles, want 0", stray); end
  endtask

  task automatic test_contention();
    logic [2:0] g; logic [DATA_W-1:0] d; logic [NUM_REQ-1:0] a, dn;
    int lat, cyc, extra; bit ok, err; exp_t e;
`ifdef UART_ARB_FIXED_PRIO_EN
    int order[4] = '{0, 0, 0, 0};
`else
    int order[4] = '{0, 1, 0, 1};
`endif
    do_reset();
    bus.req = 4'b0011;
    foreach (order[k]) sb.push_back(exp_of(order[k]));
    for (int n = 0; n < 4; n++) begin
      wait_send(g, d, a, lat, ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || g !== e.idx || d !== e.data || a !== (NUM_REQ'(1) << e.idx)) begin
        n_fail++;
        $display("FAIL contention_send[%0d]: grant=%0d data=%h ack=%b, want grant=%0d data=%h", n, g, d, a, e.idx, e.data);
      end
      wait_done(dn, err, cyc, extra, ok);
      n_checks++;
      if (!ok || err || dn !== (NUM_REQ'(1) << e.idx) || extra != 0) begin
        n_fail++;
        $display("FAIL contention_done[%0d]: done=%b err=%0d extra=%0d, want done for %0d", n, dn, err, extra, e.idx);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_rotation();
    logic [2:0] g; logic [DATA_W-1:0] d; logic [NUM_REQ-1:0] a, dn;
    int lat, cyc, extra; bit ok, err; exp_t e;
`ifdef UART_ARB_FIXED_PRIO_EN
    int order[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    int order[10] = '{0, 1, 2, 3, 0, 2, 3, 0, 2, 3};
`endif
    do_reset();
    bus.req = 4'b1111;
    foreach (order[k]) sb.push_back(exp_of(order[k]));
    for (int n = 0; n < 10; n++) begin
      wait_send(g, d, a, lat, ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || g !== e.idx || d !== e.data || a !== (NUM_REQ'(1) << e.idx)) begin
        n_fail++;
        $display("FAIL rotation_send[%0d]: grant=%0d data=%h ack=%b, want grant=%0d data=%h", n, g, d, a, e.idx, e.data);
      end
      if (n == 4) bus.req[1] = 1'b0;
      wait_done(dn, err, cyc, extra, ok);
      n_checks++;
      if (!ok || err || dn !== (NUM_REQ'(1) << e.idx)) begin
        n_fail++;
        $display("FAIL rotation_done[%0d]: done=%b err=%0d, want done for %0d", n, dn, err, e.idx);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_prio();
    logic [2:0] g; logic [DATA_W-1:0] d; logic [NUM_REQ-1:0] a, dn;
    int lat, cyc, extra; bit ok, err; exp_t e;
`ifdef UART_ARB_FIXED_PRIO_EN
    int order[4] = '{0, 0, 0, 2};
`else
    int order[4] = '{0, 2, 0, 2};
`endif
    do_reset();
    bus.req = 4'b0101;
    foreach (order[k]) sb.push_back(exp_of(order[k]));
    for (int n = 0; n < 4; n++) begin
      wait_send(g, d, a, lat, ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || g !== e.idx || d !== e.data) begin
        n_fail++;
        $display("FAIL prio_send[%0d]: grant=%0d data=%h, want grant=%0d data=%h", n, g, d, e.idx, e.data);
      end
      if (n == 2) bus.req[0] = 1'b0;
      wait_done(dn, err, cyc, extra, ok);
      n_checks++;
      if (!ok || err || dn !== (NUM_REQ'(1) << e.idx)) begin
        n_fail++;
        $display("FAIL prio_done[%0d]: done=%b err=%0d, want done for %0d", n, dn, err, e.idx);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_timeout();
    logic [2:0] g; logic [DATA_W-1:0] d; logic [NUM_REQ-1:0] a, dn;
    int lat, cyc, extra; bit ok, err; exp_t e;
    do_reset();
    rdy_mode = 1;
    bus.req  = 4'b0001;
    sb.push_back(exp_of(0));
    sb.push_back(exp_of(0));
    wait_send(g, d, a, lat, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || g !== e.idx || d !== e.data) begin
      n_fail++; $display("FAIL timeout_send: grant=%0d data=%h, want grant=%0d data=%h", g, d, e.idx, e.data);
    end
    wait_done(dn, err, cyc, extra, ok);
    n_checks++;
    if (!ok || !err || dn !== '0 || cyc != RDY_TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout_err: ok=%0d err=%0d done=%b cycles=%0d, want err=1 done=0 cycles=%0d", ok, err, dn, cyc, RDY_TIMEOUT);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", bus.busy); end
    wait_send(g, d, a, lat, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || g !== e.idx || a !== 4'b0001 || lat != 1) begin
      n_fail++; $display("FAIL timeout_regrant: ok=%0d grant=%0d ack=%b lat=%0d, want grant=0 ack=0001 lat=1", ok, g, a, lat);
    end
    bus.req = '0;
    wait_done(dn, err, cyc, extra, ok);
    n_checks++;
    if (!ok || !err) begin n_fail++; $display("FAIL timeout_err2: ok=%0d err=%0d want err=1", ok, err); end
    rdy_mode = 0;
  endtask

  task automatic test_reset_midframe();
    logic [2:0] g; logic [DATA_W-1:0] d; logic [NUM_REQ-1:0] a, dn;
    int lat, cyc, extra, early; bit ok, err; exp_t e;
    do_reset();
    bus.req = 4'b0010;
    sb.push_back(exp_of(1));
    wait_send(g, d, a, lat, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || g !== e.idx || d !== e.data) begin
      n_fail++; $display("FAIL midrst_send: grant=%0d data=%h, want grant=%0d data=%h", g, d, e.idx, e.data);
    end
    bus.req  = '0;
    rdy_mode = 2;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.grant_idx !== 3'd0 || bus.uart_send !== 1'b0 ||
        bus.uart_data !== '0 || bus.ack !== '0 || bus.done !== '0) begin
      n_fail++;
      $display("FAIL midrst_clear: busy=%b grant=%0d send=%b data=%h ack=%b done=%b, want all 0",
               bus.busy, bus.grant_idx, bus.uart_send, bus.uart_data, bus.ack, bus.done);
    end
    @(negedge clk);
    bus.req = 4'b0100;
    rst     = 1'b0;
    early   = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ack != '0) early++;
    end
    n_checks++;
    if (early != 0) begin n_fail++; $display("FAIL midrst_no_ack: ack seen %0d cycles while rdy low, want 0", early); end
    rdy_mode = 0;
    sb.push_back(exp_of(2));
    wait_send(g, d, a, lat, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || g !== e.idx || d !== e.data || a !== 4'b0100) begin
      n_fail++; $display("FAIL midrst_regrant: ok=%0d grant=%0d data=%h ack=%b, want grant=2 data=%h ack=0100", ok, g, d, a, e.data);
    end
    bus.req = '0;
    wait_done(dn, err, cyc, extra, ok);
    n_checks++;
    if (!ok || err || dn !== 4'b0100) begin n_fail++; $display("FAIL midrst_done: done=%b err=%0d want done=0100", dn, err); end
  endtask

  initial begin
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_data = {8'h44, 8'h43, 8'h42, 8'h41};
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_prio();
    test_timeout();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
